// File: rtl/gen_cnt_pkg.sv
// Shared types and helpers for the generic event-counter bank.
package gen_cnt_pkg;

   typedef enum logic {
      CNT_WRAP = 1'b0,
      CNT_SAT  = 1'b1
   } cnt_mode_e;

   // Channel-index width; never zero so a one-channel bank still has a port bit.
   function automatic int ch_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/gen_cnt_ch.sv
// One counter channel: live count, sticky overflow flag and snapshot shadow register.
module gen_cnt_ch
   import gen_cnt_pkg::*;
#(
   parameter int        CNT_W       = 8,
   parameter cnt_mode_e MODE        = CNT_WRAP,
   parameter bit        CLR_ON_SNAP = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_inc,
   input  logic             i_clr,
   input  logic             i_snap,
   output logic             o_ovf,
   output logic [CNT_W-1:0] o_shadow
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_shadow;
   logic             r_ovf;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_at_max;

   assign w_at_max = &r_cnt;

   generate
      if (MODE == CNT_SAT) begin : g_sat
         assign w_cnt_inc = w_at_max ? r_cnt : r_cnt + 1'b1;
      end else begin : g_wrap
         assign w_cnt_inc = r_cnt + 1'b1;
      end
   endgenerate

   // Shadow captures the pre-edge count; clr outranks the snapshot restart, which outranks inc.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_shadow <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (i_snap) begin
            r_shadow <= r_cnt;
         end
         if (i_clr) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
         end else if (CLR_ON_SNAP && i_snap) begin
            r_cnt <= {{(CNT_W-1){1'b0}}, i_inc};
         end else if (i_inc) begin
            r_cnt <= w_cnt_inc;
            if (w_at_max) begin
               r_ovf <= 1'b1;
            end
         end
      end
   end

   assign o_ovf    = r_ovf;
   assign o_shadow = r_shadow;

endmodule

// File: rtl/gen_cnt_bank.sv
// Bank of NUM_CH event counters with a snapshot streamed out one channel per valid/ready beat.
//
//   state  | meaning
//   S_IDLE | no readout; a snap request is accepted and captures all shadows
//   S_SEND | presenting shadow[idx]; advances on each handshake, returns after the last channel
module gen_cnt_bank
   import gen_cnt_pkg::*;
#(
   parameter int        NUM_CH      = 4,
   parameter int        CNT_W       = 8,
   parameter cnt_mode_e MODE        = CNT_WRAP,
   parameter bit        CLR_ON_SNAP = 1'b0,
   localparam int       CH_W        = ch_w(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] inc,
   input  logic [NUM_CH-1:0] clr,
   input  logic              snap,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [CH_W-1:0]   out_ch,
   output logic [CNT_W-1:0]  out_cnt,
   output logic [NUM_CH-1:0] ovf,
   output logic              busy
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_e;

   localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CH - 1);

   state_e           r_state;
   logic [CH_W-1:0]  r_idx;
   logic             r_valid;
   logic             r_busy;
   logic             w_snap_acc;
   logic [CNT_W-1:0] w_shadow [NUM_CH];

   assign w_snap_acc = snap && (r_state == S_IDLE);

   generate
      for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
         gen_cnt_ch #(
            .CNT_W       (CNT_W),
            .MODE        (MODE),
            .CLR_ON_SNAP (CLR_ON_SNAP)
         ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_inc    (inc[i]),
            .i_clr    (clr[i]),
            .i_snap   (w_snap_acc),
            .o_ovf    (ovf[i]),
            .o_shadow (w_shadow[i])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (snap) begin
                  r_state <= S_SEND;
                  r_idx   <= '0;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            S_SEND: begin
               if (out_ready) begin
                  if (r_idx == LAST_IDX) begin
                     r_state <= S_IDLE;
                     r_idx   <= '0;
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = r_valid;
   assign busy      = r_busy;
   assign out_ch    = r_idx;
   assign out_cnt   = w_shadow[r_idx];

endmodule

// File: tb/tb_gen_cnt_bank.sv
// Three banks (wrap, saturate, wrap with restart-on-snapshot) driven by shared stimulus, scoreboard-checked.
module tb_gen_cnt_bank;
   import gen_cnt_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] inc = '0;
   logic [3:0] clr = '0;
   logic       snap = 1'b0;
   logic       ready = 1'b1;

   logic       ov   [3];
   logic [1:0] och  [3];
   logic [3:0] ocnt [3];
   logic [3:0] oovf [3];
   logic       obusy[3];

   // entry = {c.ch, c.cnt, s.ch, s.cnt, w.ch, w.cnt}
   logic [17:0] q[$];
   int n_cmp = 0;
   int n_err = 0;
   int n_hs  = 0;

   always #5 clk = ~clk;

   gen_cnt_bank #(.NUM_CH(4), .CNT_W(4), .MODE(CNT_WRAP), .CLR_ON_SNAP(1'b0)) u_wrap (
      .clk(clk), .rst_n(rst_n), .inc(inc), .clr(clr), .snap(snap), .out_ready(ready),
      .out_valid(ov[0]), .out_ch(och[0]), .out_cnt(ocnt[0]), .ovf(oovf[0]), .busy(obusy[0]));
   gen_cnt_bank #(.NUM_CH(4), .CNT_W(4), .MODE(CNT_SAT), .CLR_ON_SNAP(1'b0)) u_sat (
      .clk(clk), .rst_n(rst_n), .inc(inc), .clr(clr), .snap(snap), .out_ready(ready),
      .out_valid(ov[1]), .out_ch(och[1]), .out_cnt(ocnt[1]), .ovf(oovf[1]), .busy(obusy[1]));
   gen_cnt_bank #(.NUM_CH(4), .CNT_W(4), .MODE(CNT_WRAP), .CLR_ON_SNAP(1'b1)) u_cos (
      .clk(clk), .rst_n(rst_n), .inc(inc), .clr(clr), .snap(snap), .out_ready(ready),
      .out_valid(ov[2]), .out_ch(och[2]), .out_cnt(ocnt[2]), .ovf(oovf[2]), .busy(obusy[2]));

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", name, d, act, exp, $time);
      end
   endtask

   // Monitor: every presented beat is compared with the queue head; popped on handshake.
   always @(negedge clk) begin
      if (rst_n && (ov[0] || ov[1] || ov[2])) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL extra_beat: got a beat expected none (t=%0t)", $time);
         end else begin
            for (int d = 0; d < 3; d++) begin
               chk("beat_valid", d, 32'(ov[d]), 32'd1);
               chk("beat_ch", d, 32'(och[d]), 32'(q[0][d*6+4 +: 2]));
               chk("beat_cnt", d, 32'(ocnt[d]), 32'(q[0][d*6 +: 4]));
            end
            if (ready) begin
               void'(q.pop_front());
               n_hs++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_beat(input int ch, input int cw, input int cs, input int cc);
      q.push_back({2'(ch), 4'(cc), 2'(ch), 4'(cs), 2'(ch), 4'(cw)});
   endtask

   task automatic push_all(input logic [15:0] w, input logic [15:0] s, input logic [15:0] c);
      for (int ch = 0; ch < 4; ch++)
         push_beat(ch, int'(w[ch*4 +: 4]), int'(s[ch*4 +: 4]), int'(c[ch*4 +: 4]));
   endtask

   task automatic check_ovf(input logic [3:0] ew, input logic [3:0] es, input logic [3:0] ec);
      @(negedge clk);
      chk("ovf", 0, 32'(oovf[0]), 32'(ew));
      chk("ovf", 1, 32'(oovf[1]), 32'(es));
      chk("ovf", 2, 32'(oovf[2]), 32'(ec));
   endtask

   task automatic check_busy(input string name, input logic eb);
      for (int d = 0; d < 3; d++) chk(name, d, 32'(obusy[d]), 32'(eb));
   endtask

   task automatic check_idle_outputs(input string name);
      for (int d = 0; d < 3; d++) begin
         chk({name, "_valid"}, d, 32'(ov[d]), 32'd0);
         chk({name, "_busy"}, d, 32'(obusy[d]), 32'd0);
         chk({name, "_ch"}, d, 32'(och[d]), 32'd0);
         chk({name, "_cnt"}, d, 32'(ocnt[d]), 32'd0);
         chk({name, "_ovf"}, d, 32'(oovf[d]), 32'd0);
      end
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!obusy[0] && !obusy[1] && !obusy[2]) begin
            chk("queue_drained", 0, 32'(q.size()), 32'd0);
            return;
         end
      end
      n_cmp++;
      n_err++;
      $display("FAIL wait_idle: got busy after 40 cycles expected idle");
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      inc = '0; clr = '0; snap = 1'b0; ready = 1'b1;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic pulse_inc(input logic [3:0] m, input int n);
      inc = m;
      repeat (n) tick();
      inc = '0;
   endtask

   task automatic snap_drain();
      snap = 1'b1; ready = 1'b1;
      tick();
      snap = 1'b0;
      wait_idle();
   endtask

   logic [6:0] rdy_pat;
   int hs0;

   initial begin
      // Reset state
      do_reset();
      @(negedge clk);
      check_idle_outputs("reset");

      // 17 incs on ch2: wrap -> 1, sat -> 15
      pulse_inc(4'b0100, 17);
      check_ovf(4'b0100, 4'b0100, 4'b0100);
      push_all(16'h0100, 16'h0F00, 16'h0100);
      snap_drain();
      check_ovf(4'b0100, 4'b0100, 4'b0100);

      // 20 incs on ch0, then clr with inc on ch0
      do_reset();
      pulse_inc(4'b0001, 20);
      check_ovf(4'b0001, 4'b0001, 4'b0001);
      push_all(16'h0004, 16'h000F, 16'h0004);
      snap_drain();
      inc = 4'b0001; clr = 4'b0001;
      tick();
      inc = '0; clr = '0;
      check_ovf(4'b0000, 4'b0000, 4'b0000);
      push_all(16'h0000, 16'h0000, 16'h0000);
      snap_drain();

      // Stalled readout, ready pattern 1,0,0,1,0,1,1
      do_reset();
      pulse_inc(4'b1111, 3);
      pulse_inc(4'b1010, 2);
      push_all(16'h5353, 16'h5353, 16'h5353);
      hs0 = n_hs;
      rdy_pat = 7'b1101001;
      snap = 1'b1; ready = 1'b1;
      tick();
      snap = 1'b0;
      for (int k = 0; k < 7; k++) begin
         ready = rdy_pat[k];
         if (k == 6) begin
            @(negedge clk);
            check_busy("busy_before_last", 1'b1);
         end
         tick();
      end
      ready = 1'b1;
      @(negedge clk);
      check_busy("busy_after_last", 1'b0);
      chk("handshakes", 0, 32'(n_hs - hs0), 32'd4);

      // Snapshot restart: ch1 at 5 with inc on the snap cycle
      do_reset();
      pulse_inc(4'b0010, 5);
      push_all(16'h0050, 16'h0050, 16'h0050);
      snap = 1'b1; inc = 4'b0010; ready = 1'b1;
      tick();
      snap = 1'b0; inc = '0;
      wait_idle();
      push_all(16'h0060, 16'h0060, 16'h0010);
      snap_drain();

      // snap held during SEND with inc on ch3: ignored, single readout
      do_reset();
      pulse_inc(4'b0001, 2);
      push_all(16'h0002, 16'h0002, 16'h0002);
      hs0 = n_hs;
      snap = 1'b1; ready = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) begin
         snap = 1'b1; inc = 4'b1000;
         tick();
      end
      snap = 1'b0; inc = '0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_busy("no_second_readout", 1'b0);
      end
      chk("single_readout", 0, 32'(n_hs - hs0), 32'd4);
      push_all(16'h4002, 16'h4002, 16'h4000);
      snap_drain();

      // Reset during beat 2 of a readout
      do_reset();
      pulse_inc(4'b0001, 16);
      pulse_inc(4'b1111, 2);
      push_beat(0, 2, 15, 2);
      push_beat(1, 2, 2, 2);
      snap = 1'b1; ready = 1'b1;
      tick();
      snap = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check_idle_outputs("async_reset");
      chk("aborted_queue", 0, 32'(q.size()), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      push_all(16'h0000, 16'h0000, 16'h0000);
      snap_drain();
      check_ovf(4'b0000, 4'b0000, 4'b0000);

      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
